// File: rtl/counter_sequencer_if.sv
// Request/grant bundle between the clients and the shared-timer sequencer.
// Optional abort/aborted pair is present only when CSEQ_ABORT_EN is defined.
interface counter_sequencer_if #(
  parameter int NREQ = 4,
  parameter int CW   = 8
);
  logic [NREQ-1:0]    req;
  logic [NREQ*CW-1:0] len;
  logic               tick;
  logic [NREQ-1:0]    grant;
  logic               busy;
  logic [NREQ-1:0]    done;
  logic [CW-1:0]      count_out;
`ifdef CSEQ_ABORT_EN
  logic               abort;
  logic               aborted;
`endif

  modport master (
`ifdef CSEQ_ABORT_EN
    output abort,
    input  aborted,
`endif
    output req, len, tick,
    input  grant, busy, done, count_out
  );

  modport slave (
`ifdef CSEQ_ABORT_EN
    input  abort,
    output aborted,
`endif
    input  req, len, tick,
    output grant, busy, done, count_out
  );
endinterface

// File: rtl/counter_sequencer.sv
// Round-robin sequencer sharing one down-counter between NREQ requesters.
// Define CSEQ_ABORT_EN to add the abort input / aborted pulse output.
//
// state | meaning
// IDLE  | waiting; req sampled, round-robin winner chosen
// LOAD  | grant asserted, counter loaded from winner's len slice
// RUN   | counter decrements on tick
// DONE  | one-cycle done pulse, pointer advances
module counter_sequencer #(
  parameter int NREQ = 4,
  parameter int CW   = 8
) (
  input logic               clk,
  input logic               reset,
  counter_sequencer_if.slave bus
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    RUN  = 2'b10,
    DONE = 2'b11
  } state_t;

  state_t          state;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   winner;
  logic [IW-1:0]   pick;
  logic [IW-1:0]   next_ptr;
  logic [CW-1:0]   count;
  logic [CW-1:0]   load_val;
  logic [NREQ-1:0] grant_q;
  logic [NREQ-1:0] done_q;
  logic            busy_q;
  logic            abort_hit;

`ifdef CSEQ_ABORT_EN
  logic            aborted_q;
  assign abort_hit   = bus.abort;
  assign bus.aborted = aborted_q;
`else
  assign abort_hit   = 1'b0;
`endif

  // Scan downward so the smallest offset from ptr is the last (winning) write.
  always_comb begin
    pick = ptr;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (bus.req[(int'(ptr) + k) % NREQ]) pick = IW'((int'(ptr) + k) % NREQ);
    end
  end

  assign next_ptr = (winner == IW'(NREQ - 1)) ? '0 : winner + 1'b1;
  assign load_val = bus.len[int'(winner)*CW +: CW];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      ptr     <= '0;
      winner  <= '0;
      count   <= '0;
      grant_q <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
`ifdef CSEQ_ABORT_EN
      aborted_q <= 1'b0;
`endif
    end else begin
      done_q <= '0;
`ifdef CSEQ_ABORT_EN
      aborted_q <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (|bus.req) begin
            winner  <= pick;
            grant_q <= NREQ'(1) << pick;
            busy_q  <= 1'b1;
            state   <= LOAD;
          end
        end
        LOAD, RUN: begin
          if (abort_hit) begin
            state   <= IDLE;
            count   <= '0;
            grant_q <= '0;
            busy_q  <= 1'b0;
            ptr     <= next_ptr;
`ifdef CSEQ_ABORT_EN
            aborted_q <= 1'b1;
`endif
          end else if (state == LOAD) begin
            count <= load_val;
            if (load_val == '0) begin
              state  <= DONE;
              done_q <= grant_q;
            end else begin
              state <= RUN;
            end
          end else if (bus.tick) begin
            // Clamp at zero so the counter can never wrap.
            if (count <= CW'(1)) begin
              count  <= '0;
              state  <= DONE;
              done_q <= grant_q;
            end else begin
              count <= count - 1'b1;
            end
          end
        end
        DONE: begin
          ptr     <= next_ptr;
          grant_q <= '0;
          busy_q  <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          state   <= IDLE;
          grant_q <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.grant     = grant_q;
  assign bus.done      = done_q;
  assign bus.busy      = busy_q;
  assign bus.count_out = count;
endmodule

// File: tb/tb_counter_sequencer.sv
// Scoreboard bench for counter_sequencer: stimulus queues expected grant/done/
// aborted events and count_out samples; a negedge monitor pops and compares.
module tb_counter_sequencer;
  localparam int NREQ = 4;
  localparam int CW   = 8;
  localparam int K_GRANT = 0;
  localparam int K_DONE  = 1;
  localparam int K_ABORT = 2;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  counter_sequencer_if #(.NREQ(NREQ), .CW(CW)) bus();
  counter_sequencer #(.NREQ(NREQ), .CW(CW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    int kind;
    int val;
    int cyc;
  } ev_t;

  ev_t ev_q[$];
  ev_t cnt_q[$];
  int  errors = 0;
  int  checks = 0;
  logic [NREQ-1:0] prev_grant = '0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_ev(int kind, int val, int at);
    ev_q.push_back('{kind, val, at});
  endtask

  task automatic expect_cnt(int val, int at);
    cnt_q.push_back('{K_GRANT, val, at});
  endtask

  task automatic got_ev(int kind, int val);
    ev_t e;
    checks++;
    if (ev_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: kind=%0d val=%0d cycle=%0d", kind, val, cyc);
    end else begin
      e = ev_q.pop_front();
      if (e.kind != kind || e.val != val || e.cyc != cyc) begin
        errors++;
        $display("FAIL event: got kind=%0d val=%0d cycle=%0d expected kind=%0d val=%0d cycle=%0d",
                 kind, val, cyc, e.kind, e.val, e.cyc);
      end
    end
  endtask

  always @(negedge clk) begin
    ev_t e;
    if (bus.grant != '0 && bus.grant != prev_grant) got_ev(K_GRANT, int'(bus.grant));
    prev_grant = bus.grant;
    if (bus.done != '0) got_ev(K_DONE, int'(bus.done));
`ifdef CSEQ_ABORT_EN
    if (bus.aborted) got_ev(K_ABORT, 1);
`endif
    while (cnt_q.size() > 0 && cnt_q[0].cyc < cyc) begin
      e = cnt_q.pop_front();
      checks++;
      errors++;
      $display("FAIL count_sample_missed: expected %0d at cycle %0d", e.val, e.cyc);
    end
    if (cnt_q.size() > 0 && cnt_q[0].cyc == cyc) begin
      e = cnt_q.pop_front();
      check("count_out", 32'(bus.count_out), 32'(e.val));
    end
  end

  task automatic tick_n(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_len(int i, logic [CW-1:0] v);
    bus.len[i*CW +: CW] = v;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    tick_n(2);
    reset = 1'b0;
  endtask

  initial begin
    int c;
    bus.req  = '0;
    bus.len  = '0;
    bus.tick = 1'b1;
`ifdef CSEQ_ABORT_EN
    bus.abort = 1'b0;
`endif
    #2 reset = 1'b1;
    #1;
    check("reset_grant", 32'(bus.grant), 0);
    check("reset_busy", 32'(bus.busy), 0);
    check("reset_done", 32'(bus.done), 0);
    check("reset_count", 32'(bus.count_out), 0);
    tick_n(2);
    reset = 1'b0;

    // Single requester, len 3, tick constant.
    @(negedge clk);
    c = cyc;
    set_len(0, 3);
    bus.req = 4'b0001;
    expect_ev(K_GRANT, 1, c + 1);
    expect_cnt(3, c + 2);
    expect_cnt(2, c + 3);
    expect_cnt(1, c + 4);
    expect_cnt(0, c + 5);
    expect_ev(K_DONE, 1, c + 5);
    @(negedge clk);
    bus.req = '0;
    check("busy_in_load", 32'(bus.busy), 1);
    tick_n(5);
    check("busy_after_done", 32'(bus.busy), 0);
    check("grant_after_done", 32'(bus.grant), 0);

    // All four requesting, len 1: strict rotation, 4 cycles apart.
    do_reset();
    @(negedge clk);
    c = cyc;
    for (int i = 0; i < NREQ; i++) set_len(i, 1);
    bus.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      expect_ev(K_GRANT, 1 << (k % 4), c + 1 + 4*k);
      expect_ev(K_DONE, 1 << (k % 4), c + 3 + 4*k);
    end
    tick_n(17);
    bus.req = '0;
    tick_n(4);

    // Zero length: LOAD straight to DONE, counter stays 0.
    @(negedge clk);
    c = cyc;
    set_len(2, 0);
    bus.req = 4'b0100;
    expect_ev(K_GRANT, 4, c + 1);
    expect_cnt(0, c + 1);
    expect_cnt(0, c + 2);
    expect_ev(K_DONE, 4, c + 2);
    expect_cnt(0, c + 3);
    @(negedge clk);
    bus.req = '0;
    tick_n(2);
    check("busy_zero_len_idle", 32'(bus.busy), 0);
    tick_n(1);

    // tick pattern 1,0,1 in RUN stretches the run by one cycle.
    set_len(0, 2);
    @(negedge clk);
    c = cyc;
    bus.req = 4'b0001;
    expect_ev(K_GRANT, 1, c + 1);
    expect_cnt(2, c + 2);
    expect_cnt(1, c + 3);
    expect_cnt(1, c + 4);
    expect_cnt(0, c + 5);
    expect_ev(K_DONE, 1, c + 5);
    @(negedge clk);
    bus.req = '0;
    tick_n(2);
    bus.tick = 1'b0;
    @(negedge clk);
    bus.tick = 1'b1;
    tick_n(3);

    // Reset in the middle of RUN: outputs clear at once, no done.
    set_len(3, 5);
    @(negedge clk);
    c = cyc;
    bus.req = 4'b1000;
    expect_ev(K_GRANT, 8, c + 1);
    @(negedge clk);
    bus.req = '0;
    tick_n(2);
    #2 reset = 1'b1;
    #1;
    check("midrun_reset_grant", 32'(bus.grant), 0);
    check("midrun_reset_busy", 32'(bus.busy), 0);
    check("midrun_reset_done", 32'(bus.done), 0);
    check("midrun_reset_count", 32'(bus.count_out), 0);
    tick_n(2);
    reset = 1'b0;
    set_len(1, 1);
    @(negedge clk);
    c = cyc;
    bus.req = 4'b1010;
    expect_ev(K_GRANT, 2, c + 1);
    expect_ev(K_DONE, 2, c + 3);
    @(negedge clk);
    bus.req = '0;
    tick_n(4);

`ifdef CSEQ_ABORT_EN
    // Abort in the second RUN cycle; pointer still advances past the winner.
    set_len(0, 5);
    set_len(1, 1);
    @(negedge clk);
    c = cyc;
    bus.req = 4'b0001;
    expect_ev(K_GRANT, 1, c + 1);
    expect_cnt(5, c + 2);
    expect_cnt(4, c + 3);
    expect_cnt(0, c + 4);
    expect_ev(K_ABORT, 1, c + 4);
    expect_ev(K_GRANT, 2, c + 5);
    expect_ev(K_DONE, 2, c + 7);
    @(negedge clk);
    bus.req = 4'b0011;
    tick_n(2);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check("abort_busy", 32'(bus.busy), 0);
    @(negedge clk);
    bus.req = '0;
    tick_n(4);
`endif

    for (int i = 0; i < 50 && (ev_q.size() > 0 || cnt_q.size() > 0); i++) @(negedge clk);
    while (ev_q.size() > 0) begin
      ev_t e;
      e = ev_q.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_event: kind=%0d val=%0d expected at cycle %0d", e.kind, e.val, e.cyc);
    end
    while (cnt_q.size() > 0) begin
      ev_t e;
      e = cnt_q.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_count: expected %0d at cycle %0d", e.val, e.cyc);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
